tx_frame_sequencer: RTL and testbench

Transmit-side controller for the transceiver datapath. It buffers received bytes from the UART receiver and hands each one to the channel encoder. It then serialises the 12-bit codeword MSB-first, holding each bit for a fixed number of carrier samples, and drives the sample-phase counter and bit select used by the modulator's sin/neg_sin selection. It sits between uart_rx and the encoder/modulator inside transceiver_top and replaces the free-running counter/enable sequencing.

---
 rtl/tx_seq_pkg.sv | 15 +
 rtl/tx_frame_sequencer_if.sv | 12 +
 rtl/tx_byte_fifo.sv | 54 +++++
 rtl/tx_frame_sequencer.sv | 140 ++++++++++++++
 tb/tb_tx_frame_sequencer.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/tx_seq_pkg.sv
// Shared types and default widths for the transmit frame sequencer.
package tx_seq_pkg;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_CODE_W = 12;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    ENC  = 3'd2,
    SEND = 3'd3,
    GAP  = 3'd4
  } state_e;

endpackage

// File: rtl/tx_frame_sequencer_if.sv
// Byte stream from the UART receiver into the frame sequencer buffer.
interface tx_frame_sequencer_if #(
  parameter int unsigned DATA_W = tx_seq_pkg::DEF_DATA_W
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              overflow;

  modport master (output in_data, in_valid, input in_ready, overflow);
  modport slave  (input in_data, in_valid, output in_ready, overflow);
endinterface

// File: rtl/tx_byte_fifo.sv
// Small synchronous byte FIFO; pointers carry an extra wrap bit for full/empty.
module tx_byte_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              ready_o
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic              push, pop, full_d, ready_q;

  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign push    = wr_en_i && !full_o;
  assign pop     = rd_en_i && !empty_o;
  assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    full_d = (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
  end

  // ready is registered from next-state fullness so it always mirrors !full
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ready_q  <= !full_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

  assign ready_o = ready_q;
endmodule

// File: rtl/tx_frame_sequencer.sv
// Buffers UART bytes, fetches each codeword from the encoder and serialises it
// MSB-first, one bit per SAMPLES_PER_BIT carrier samples, with an idle gap.
module tx_frame_sequencer
  import tx_seq_pkg::*;
#(
  parameter int unsigned DATA_W          = DEF_DATA_W,
  parameter int unsigned CODE_W          = DEF_CODE_W,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned SAMPLES_PER_BIT = 256,
  parameter int unsigned PH_W            = $clog2(SAMPLES_PER_BIT),
  parameter int unsigned ENC_LAT         = 1,
  parameter int unsigned GAP_CYCLES      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en_i,
  tx_frame_sequencer_if.slave   in_if,
  output logic [DATA_W-1:0]     enc_data_o,
  input  logic [CODE_W-1:0]     enc_code_i,
  output logic                  bit_out_o,
  output logic [PH_W-1:0]       phase_cnt_o,
  output logic                  sym_start_o,
  output logic                  active_o,
  output logic                  done_o
);
  localparam int unsigned CNT_MAX  = (ENC_LAT > GAP_CYCLES) ? ENC_LAT : GAP_CYCLES;
  localparam int unsigned CNT_W    = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
  localparam int unsigned BW       = $clog2(CODE_W);
  localparam int unsigned GAP_LAST = (GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [BW-1:0]     bidx_q, bidx_d;
  logic [CODE_W-1:0] shreg_q, shreg_d;
  logic [DATA_W-1:0] enc_data_q, enc_data_d, fifo_head;
  logic              pop, fifo_full, fifo_empty;
  logic              bit_q, sym_q, active_q, done_q, done_d, ovf_q;

  tx_byte_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (in_if.in_valid),
    .wr_data_i (in_if.in_data),
    .rd_en_i   (pop),
    .rd_data_o (fifo_head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .ready_o   (in_if.in_ready)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    phase_d    = phase_q;
    bidx_d     = bidx_q;
    shreg_d    = shreg_q;
    enc_data_d = enc_data_q;
    pop        = 1'b0;
    done_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        phase_d = '0;
        if (en_i && !fifo_empty) begin
          pop        = 1'b1;
          enc_data_d = fifo_head;
          state_d    = LOAD;
        end
      end
      LOAD: begin
        cnt_d   = '0;
        state_d = ENC;
      end
      ENC: begin
        if (cnt_q == CNT_W'(ENC_LAT - 1)) begin
          shreg_d = enc_code_i;
          phase_d = '0;
          bidx_d  = '0;
          state_d = SEND;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SEND: begin
        phase_d = phase_q + 1'b1;
        if (phase_q == PH_W'(SAMPLES_PER_BIT - 1)) begin
          shreg_d = {shreg_q[CODE_W-2:0], 1'b0};
          bidx_d  = bidx_q + 1'b1;
          if (bidx_q == BW'(CODE_W - 1)) begin
            done_d  = 1'b1;
            cnt_d   = '0;
            state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
          end
        end
      end
      GAP: begin
        phase_d = '0;
        if (cnt_q == CNT_W'(GAP_LAST)) state_d = IDLE;
        else                           cnt_d = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      phase_q    <= '0;
      bidx_q     <= '0;
      shreg_q    <= '0;
      enc_data_q <= '0;
      bit_q      <= 1'b0;
      sym_q      <= 1'b0;
      active_q   <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
      bidx_q     <= bidx_d;
      shreg_q    <= shreg_d;
      enc_data_q <= enc_data_d;
      bit_q      <= (state_d == SEND) && shreg_d[CODE_W-1];
      sym_q      <= (state_d == SEND) && (phase_d == '0);
      active_q   <= (state_d != IDLE);
      done_q     <= done_d;
      ovf_q      <= in_if.in_valid && fifo_full;
    end
  end

  assign in_if.overflow = ovf_q;
  assign enc_data_o     = enc_data_q;
  assign bit_out_o      = bit_q;
  assign phase_cnt_o    = phase_q;
  assign sym_start_o    = sym_q;
  assign active_o       = active_q;
  assign done_o         = done_q;
endmodule

// File: tb/tb_tx_frame_sequencer.sv
// Directed bench for tx_frame_sequencer: SAMPLES_PER_BIT=4, GAP_CYCLES=2, ENC_LAT=1.
module tb_tx_frame_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [7:0]  enc_data;
  logic [11:0] enc_code = '0;
  logic        bit_out, sym_start, active, done;
  logic [1:0]  phase_cnt;
  int          n_checks = 0;
  int          n_fail = 0;
  int          done_cnt = 0;
  int          ov_cnt = 0;

  tx_frame_sequencer_if #(.DATA_W(8)) in_if ();

  tx_frame_sequencer #(
    .DATA_W(8), .CODE_W(12), .FIFO_DEPTH(4), .SAMPLES_PER_BIT(4),
    .PH_W(2), .ENC_LAT(1), .GAP_CYCLES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en_i(en), .in_if(in_if.slave),
    .enc_data_o(enc_data), .enc_code_i(enc_code), .bit_out_o(bit_out),
    .phase_cnt_o(phase_cnt), .sym_start_o(sym_start), .active_o(active),
    .done_o(done)
  );

  always #5 clk = ~clk;

  // encoder model: one-cycle registered {4'hC, byte}
  always @(posedge clk) enc_code <= {4'hC, enc_data};
  always @(posedge clk) begin
    if (done) done_cnt++;
    if (in_if.overflow) ov_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    in_if.in_data  = b;
    in_if.in_valid = 1'b1;
    tick();
    in_if.in_valid = 1'b0;
  endtask

  // Waits for the first sym_start, checks all 48 samples, then done on the next cycle.
  task automatic expect_frame(input logic [11:0] code, input string tag, input int drop_at,
                              output int waited);
    logic [11:0] c;
    c = code;
    waited = 0;
    while (sym_start !== 1'b1 && waited < 40) begin
      tick();
      waited++;
    end
    check({tag, "_start"}, 32'(sym_start), 32'd1);
    for (int i = 0; i < 48; i++) begin
      if (i == drop_at) en = 1'b0;
      check({tag, "_bit"}, 32'(bit_out), 32'(c[11 - i/4]));
      check({tag, "_phase"}, 32'(phase_cnt), 32'(i % 4));
      tick();
    end
    check({tag, "_done"}, 32'(done), 32'd1);
  endtask

  initial begin
    int w, d0, o0;
    in_if.in_data  = '0;
    in_if.in_valid = 1'b0;

    // reset state
    #2;
    check("rst_bit", 32'(bit_out), 32'd0);
    check("rst_phase", 32'(phase_cnt), 32'd0);
    check("rst_active", 32'(active), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ready", 32'(in_if.in_ready), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("ready_after_rst", 32'(in_if.in_ready), 32'd1);

    // single byte 0xA5, exact latency and frame timing
    en = 1'b1;
    push(8'hA5);
    check("a5_active_load", 32'(active), 32'd0);
    expect_frame(12'hCA5, "a5", -1, w);
    check("a5_latency", 32'(w), 32'd3);
    tick();
    check("a5_done_pulse", 32'(done), 32'd0);
    check("a5_active_gap", 32'(active), 32'd1);
    tick();
    check("a5_active_fall", 32'(active), 32'd0);

    // three back-to-back bytes
    d0 = done_cnt;
    o0 = ov_cnt;
    push(8'h01);
    push(8'h02);
    push(8'h03);
    expect_frame(12'hC01, "b01", -1, w);
    expect_frame(12'hC02, "b02", -1, w);
    check("b02_spacing", 32'(w), 32'd5);
    expect_frame(12'hC03, "b03", -1, w);
    check("b03_spacing", 32'(w), 32'd5);
    tick();
    check("b_done_count", 32'(done_cnt - d0), 32'd3);
    check("b_no_overflow", 32'(ov_cnt - o0), 32'd0);

    // fill while disabled, overflow on 5th and 6th
    en = 1'b0;
    repeat (4) tick();
    check("fill_idle", 32'(active), 32'd0);
    d0 = done_cnt;
    o0 = ov_cnt;
    for (int k = 0; k < 6; k++) begin
      push(8'h10 + 8'(k));
      check("fill_ready", 32'(in_if.in_ready), (k < 3) ? 32'd1 : 32'd0);
      check("fill_overflow", 32'(in_if.overflow), (k >= 4) ? 32'd1 : 32'd0);
    end
    tick();
    check("fill_overflow_end", 32'(in_if.overflow), 32'd0);
    check("fill_ov_count", 32'(ov_cnt - o0), 32'd2);
    en = 1'b1;
    expect_frame(12'hC10, "f10", -1, w);
    expect_frame(12'hC11, "f11", -1, w);
    check("f11_spacing", 32'(w), 32'd5);
    expect_frame(12'hC12, "f12", -1, w);
    expect_frame(12'hC13, "f13", -1, w);
    repeat (12) tick();
    check("fill_only_four", 32'(active), 32'd0);
    check("fill_done_count", 32'(done_cnt - d0), 32'd4);

    // en dropped at bit 5: frame completes, two bytes stay buffered
    push(8'h21);
    push(8'h22);
    push(8'h23);
    expect_frame(12'hC21, "e21", 20, w);
    repeat (10) tick();
    check("en_hold_idle", 32'(active), 32'd0);
    check("en_hold_ready", 32'(in_if.in_ready), 32'd1);
    en = 1'b1;
    expect_frame(12'hC22, "e22", -1, w);
    check("e22_resume_latency", 32'(w), 32'd3);
    expect_frame(12'hC23, "e23", -1, w);
    check("e23_spacing", 32'(w), 32'd5);

    // reset during SEND, bit 7 phase 1
    push(8'h5A);
    push(8'h77);
    d0 = done_cnt;
    w = 0;
    while (sym_start !== 1'b1 && w < 40) begin
      tick();
      w++;
    end
    check("r_start", 32'(sym_start), 32'd1);
    repeat (29) tick();
    check("r_bit7_pre", 32'(bit_out), 32'd1);
    check("r_phase_pre", 32'(phase_cnt), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("r_bit_async", 32'(bit_out), 32'd0);
    check("r_phase_async", 32'(phase_cnt), 32'd0);
    check("r_active_async", 32'(active), 32'd0);
    check("r_ready_async", 32'(in_if.in_ready), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("r_ready_release", 32'(in_if.in_ready), 32'd1);
    repeat (10) tick();
    check("r_fifo_empty", 32'(active), 32'd0);
    check("r_no_done", 32'(done_cnt - d0), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
